iomem_timer: RTL

Memory-mapped 32-bit timer/counter on the picosoc `iomem` peripheral bus, alongside the GPIO register. It decodes its own address window, answers bus accesses with a single-cycle `iomem_ready` pulse and raises a level interrupt on compare match. Its `irq` output feeds one of the SoC's spare IRQ inputs (`irq_5`).

---
 rtl/iomem_timer.sv | 139 +++++++++++++
 1 files changed

// File: rtl/iomem_timer.sv
// iomem_timer: memory-mapped 32-bit timer/counter with compare-match IRQ.
// Optional PWM output and DUTY register when IOMEM_TIMER_PWM_EN is defined.
module iomem_timer #(
    parameter logic [7:0] ADDR_BASE = 8'h04
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        iomem_valid,
    output logic        iomem_ready,
    input  logic [3:0]  iomem_wstrb,
    input  logic [31:0] iomem_addr,
    input  logic [31:0] iomem_wdata,
    output logic [31:0] iomem_rdata,
    output logic        irq
`ifdef IOMEM_TIMER_PWM_EN
    ,
    output logic        pwm_out
`endif
);

    logic        en;
    logic        periodic;
    logic        irq_en;
    logic [15:0] prescale;
    logic [15:0] psc;
    logic [31:0] compare;
    logic [31:0] count;
    logic        match;
`ifdef IOMEM_TIMER_PWM_EN
    logic [31:0] duty;
`endif

    logic        sel;
    logic        wr;
    logic [2:0]  idx;
    logic        tick;
    logic        hit;
    logic        w1c;
    logic [31:0] rd_mux;

    wire unused_addr = ^{iomem_addr[23:5], iomem_addr[1:0]};

    function automatic logic [31:0] merge(
        input logic [31:0] old,
        input logic [31:0] wd,
        input logic [3:0]  be
    );
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
        end
        return r;
    endfunction

    assign sel  = iomem_valid && !iomem_ready
               && (iomem_addr[31:24] == ADDR_BASE);
    assign wr   = sel && (iomem_wstrb != 4'b0000);
    assign idx  = iomem_addr[4:2];
    assign tick = en && (psc == prescale);
    assign hit  = tick && (count == compare);
    assign w1c  = wr && (idx == 3'd4) && iomem_wstrb[0] && iomem_wdata[0];
    assign irq  = match & irq_en;

    always_comb begin
        rd_mux = 32'h0;
        case (idx)
            3'd0: rd_mux = {29'h0, irq_en, periodic, en};
            3'd1: rd_mux = {16'h0, prescale};
            3'd2: rd_mux = compare;
            3'd3: rd_mux = count;
            3'd4: rd_mux = {31'h0, match};
`ifdef IOMEM_TIMER_PWM_EN
            3'd5: rd_mux = duty;
`endif
            default: rd_mux = 32'h0;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            iomem_ready <= 1'b0;
            iomem_rdata <= 32'h0;
            en          <= 1'b0;
            periodic    <= 1'b0;
            irq_en      <= 1'b0;
            prescale    <= 16'h0;
            psc         <= 16'h0;
            compare     <= 32'h0;
            count       <= 32'h0;
            match       <= 1'b0;
        end else begin
            iomem_ready <= sel;
            iomem_rdata <= sel ? rd_mux : 32'h0;

            if ((wr && idx == 3'd3) || !en || tick) psc <= 16'h0;
            else psc <= psc + 16'd1;

            // Bus writes take priority over the tick update.
            if (wr && idx == 3'd3) begin
                count <= merge(count, iomem_wdata, iomem_wstrb);
            end else if (tick) begin
                if (!hit) count <= count + 32'd1;
                else if (periodic) count <= 32'h0;
            end

            if (wr && idx == 3'd0) begin
                if (iomem_wstrb[0]) {irq_en, periodic, en} <= iomem_wdata[2:0];
            end else if (hit && !periodic) begin
                en <= 1'b0;
            end

            if (wr && idx == 3'd1) begin
                if (iomem_wstrb[0]) prescale[7:0]  <= iomem_wdata[7:0];
                if (iomem_wstrb[1]) prescale[15:8] <= iomem_wdata[15:8];
            end

            if (wr && idx == 3'd2)
                compare <= merge(compare, iomem_wdata, iomem_wstrb);

            // A same-cycle match set beats the W1C clear.
            match <= hit | (match & ~w1c);
        end
    end

`ifdef IOMEM_TIMER_PWM_EN
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            duty    <= 32'h0;
            pwm_out <= 1'b0;
        end else begin
            if (wr && idx == 3'd5)
                duty <= merge(duty, iomem_wdata, iomem_wstrb);
            pwm_out <= en && (count < duty);
        end
    end
`endif

endmodule
